proj_to_affine: RTL and testbench
=================================

# proj_to_affine

Converts the projective twisted-Edwards result of the scalar multiplier into affine coordinates, computing x/Z and y/Z mod p, where p = 2^255 − 19. It sits directly downstream of the scalar multiplier: its `o_x`/`o_y`/`o_z`/`o_finished` drive this block's `i_x`/`i_y`/`i_z`/`i_start`. It computes Z^-1 by Fermat exponentiation, Z^(p−2), using left-to-right square-and-multiply on one shared bit-serial modular multiplier, then applies two final multiplies.

## Interface
- `P`, default 2^255−19: field modulus.
- `E`, default 2^255−21 (= P−2): inversion exponent. Bit 254 is 1. Bits 4 and 2 are 0. All other bits are 1.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  one-cycle request; sampled only in IDLE.
- `i_x`, `i_y`, `i_z`  in  255 each  projective point. All must be < P (caller contract).
- `o_x`, `o_y`  out  255 each  affine result, always < P. Held until the next completion.
- `o_busy`  out  1  high from the cycle after an accepted start through the cycle o_finished rises.
- `o_finished`  out  1  one-cycle pulse; o_x/o_y are valid in the same cycle.

## Operation
- States: IDLE, SQR, MUL, FIN_X, FIN_Y.
- IDLE, on i_start:
  - latch x and y;
  - acc ← i_z, bit index k ← 253;
  - start the multiplier on (i_z, i_z);
  - go to SQR.
- SQR, on mul done:
  - acc ← result.
  - If E[k] = 1: start mul(acc', zsave) and go to MUL.
  - Else, if k > 0: k ← k−1, start a square, stay in SQR.
  - Else (k = 0): start mul(x, acc') and go to FIN_X.
- MUL, on mul done:
  - acc ← result.
  - If k > 0: k ← k−1, start a square, go to SQR.
  - Else: start mul(x, acc'), go to FIN_X.
- FIN_X, on done: o_x ← result; start mul(y, acc); go to FIN_Y.
- FIN_Y, on done: o_y ← result; o_finished ← 1; go to IDLE.
- The next multiply is always started in the same cycle as the previous done. There are no bubbles.
- Multiply count: 254 squares + 252 multiplies + 2 final = 508.
- Z = 0 → o_x = o_y = 0 (0^(p−2) = 0). No error flag.
- i_start while busy is ignored.
- Reset at any time:
  - state → IDLE;
  - o_x = o_y = 0, o_busy = 0, o_finished = 0;
  - multiplier aborted.

Sub-module mod_mul (interleaved Blakley):
- Operands a, b < P.
- r ← 0; for i = 254 down to 0:
  - r ← 2r;
  - if r ≥ P, r ← r − P;
  - if b[i], r ← r + a;
  - if r ≥ P, r ← r − P.
- Internal width is 256 bits. Output r < P.

## Timing
- mod_mul:
  - i_start sampled in cycle t; operands load at the end of cycle t.
  - 255 iterations on edges t+1 … t+255.
  - o_done is a registered 1-cycle pulse in cycle t+256, with o_r valid.
  - i_start while busy is ignored.
- proj_to_affine:
  - i_start sampled in cycle 0.
  - o_finished rises in cycle 508·256 + 1 = 130049.
  - o_busy is high in cycles 1…130049.
  - A new start is accepted in cycle 130050 at the earliest.
- Reset values: all outputs 0. The internal acc and the latched operands are also 0.

## Structure
- Shared package `ed25519_pkg` holds:
  - `P` and `E` as 255-bit localparams;
  - the state enum typedef;
  - the curve constant `D`, for reuse by the scalar multiplier.
- One sub-module: `mod_mul`, about 80 lines.
- The top FSM plus registers is about 150 lines.

## Test plan
- mod_mul alone:
  - a = P−1, b = P−1 → o_r = 1, o_done exactly 256 cycles after start.
  - a = 3, b = 5 → 15.
- x = 2, y = 4, z = 2 → o_x = 1, o_y = 2; o_finished at cycle 130049; o_busy profile as specified.
- z = 1, x = Bx, y = By (base point) → outputs equal the inputs.
- z = P−1, x = 5, y = 7 → o_x = P−5, o_y = P−7.
- z = 0, x = 9, y = 9 → o_x = o_y = 0.
- Start, then a second i_start at cycle 1000 → ignored, single o_finished.
- Assert i_rst at cycle 50000:
  - all outputs 0 next cycle, state IDLE;
  - a fresh start completes correctly after 130049 cycles.

Source files
------------

// File: rtl/ed25519_pkg.sv
// ed25519_pkg: shared field constants and types for the Ed25519 datapath.
//   FIELD_W  - width of a field element
//   P        - field modulus 2^255 - 19
//   E        - inversion exponent P - 2 (Fermat)
//   D        - twisted-Edwards curve constant -121665/121666 mod P
//   state_e  - proj_to_affine controller states
package ed25519_pkg;

    localparam int unsigned FIELD_W = 255;

    localparam logic [FIELD_W-1:0] P =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    localparam logic [FIELD_W-1:0] E =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;

    localparam logic [FIELD_W-1:0] D =
        255'h52036cee_2b6ffe73_8cc74079_7779e898_00700a4d_4141d8ab_75eb4dca_135978a3;

    typedef enum logic [2:0] {
        StIdle,
        StSqr,
        StMul,
        StFinX,
        StFinY
    } state_e;

endpackage

// File: rtl/mod_mul.sv
// mod_mul: bit-serial interleaved (Blakley) modular multiplier, r = a * b mod P.
//   i_clk, i_rst  - clock, synchronous active-high reset (aborts an operation)
//   i_start       - load operands; ignored while an operation is in flight
//   i_a, i_b      - operands, both < P
//   o_r           - result, < P, valid while o_done is high
//   o_done        - one-cycle pulse 256 cycles after the accepted start
module mod_mul
    import ed25519_pkg::*;
#(
    parameter logic [FIELD_W-1:0] P = ed25519_pkg::P
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [FIELD_W-1:0] i_a,
    input  logic [FIELD_W-1:0] i_b,
    output logic [FIELD_W-1:0] o_r,
    output logic               o_done
);

    logic [FIELD_W-1:0] a_q;
    logic [FIELD_W-1:0] b_q;
    logic [FIELD_W-1:0] r_q;
    logic [7:0]         idx_q;
    logic               busy_q;
    logic               done_q;

    // One iteration is computed at 256 bits: r < P keeps 2r and r + a below 2^256.
    logic [FIELD_W:0]   p_ext;
    logic [FIELD_W:0]   dbl;
    logic [FIELD_W:0]   dbl_red;
    logic [FIELD_W:0]   sum;
    logic [FIELD_W-1:0] r_d;

    always_comb begin
        p_ext   = {1'b0, P};
        dbl     = {r_q, 1'b0};
        dbl_red = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
        // b_q is shifted left each iteration, so its MSB is the current multiplier bit.
        sum     = dbl_red + (b_q[FIELD_W-1] ? {1'b0, a_q} : '0);
        r_d     = (sum >= p_ext) ? FIELD_W'(sum - p_ext) : sum[FIELD_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (i_start) begin
                    a_q    <= i_a;
                    b_q    <= i_b;
                    r_q    <= '0;
                    idx_q  <= 8'd254;
                    busy_q <= 1'b1;
                end
            end else begin
                r_q <= r_d;
                b_q <= {b_q[FIELD_W-2:0], 1'b0};
                if (idx_q == 8'd0) begin
                    // Free again in the done cycle so a chained start is not lost.
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q - 8'd1;
                end
            end
        end
    end

    assign o_r    = r_q;
    assign o_done = done_q;

endmodule

// File: rtl/proj_to_affine.sv
// proj_to_affine: converts a projective point (X:Y:Z) to affine (X/Z, Y/Z) mod P.
// Z^-1 = Z^E by left-to-right square-and-multiply on one shared mod_mul, then two
// final multiplies. Each multiply is launched in the done cycle of the previous one.
//   i_clk, i_rst       - clock, synchronous active-high reset
//   i_start            - one-cycle request, accepted only when idle
//   i_x, i_y, i_z      - projective coordinates, each < P
//   o_x, o_y           - affine result, held until the next completion
//   o_busy             - high from the cycle after accept through the o_finished cycle
//   o_finished         - one-cycle pulse, o_x/o_y valid in the same cycle
module proj_to_affine
    import ed25519_pkg::*;
#(
    parameter logic [FIELD_W-1:0] P = ed25519_pkg::P,
    parameter logic [FIELD_W-1:0] E = ed25519_pkg::E
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [FIELD_W-1:0] i_x,
    input  logic [FIELD_W-1:0] i_y,
    input  logic [FIELD_W-1:0] i_z,
    output logic [FIELD_W-1:0] o_x,
    output logic [FIELD_W-1:0] o_y,
    output logic               o_busy,
    output logic               o_finished
);

    state_e             state_q;
    logic [FIELD_W-1:0] x_q;
    logic [FIELD_W-1:0] y_q;
    logic [FIELD_W-1:0] z_q;
    logic [FIELD_W-1:0] acc_q;
    logic [7:0]         k_q;
    logic [FIELD_W-1:0] ox_q;
    logic [FIELD_W-1:0] oy_q;
    logic               busy_q;
    logic               fin_q;

    logic               mul_start;
    logic [FIELD_W-1:0] mul_a;
    logic [FIELD_W-1:0] mul_b;
    logic [FIELD_W-1:0] mul_r;
    logic               mul_done;

    logic               accept;
    logic               e_bit;
    logic               last_bit;

    // busy_q is still high in the finish cycle, which blocks a start there.
    assign accept   = (state_q == StIdle) && i_start && !busy_q;
    assign e_bit    = E[k_q];
    assign last_bit = (k_q == 8'd0);

    // Operand selection for the next multiply; uses the fresh product directly so no
    // idle cycle is spent writing it to acc_q first.
    always_comb begin
        mul_start = 1'b0;
        mul_a     = acc_q;
        mul_b     = acc_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    mul_start = 1'b1;
                    mul_a     = i_z;
                    mul_b     = i_z;
                end
            end
            StSqr: begin
                if (mul_done) begin
                    mul_start = 1'b1;
                    if (e_bit) begin
                        mul_a = mul_r;
                        mul_b = z_q;
                    end else if (!last_bit) begin
                        mul_a = mul_r;
                        mul_b = mul_r;
                    end else begin
                        mul_a = x_q;
                        mul_b = mul_r;
                    end
                end
            end
            StMul: begin
                if (mul_done) begin
                    mul_start = 1'b1;
                    if (!last_bit) begin
                        mul_a = mul_r;
                        mul_b = mul_r;
                    end else begin
                        mul_a = x_q;
                        mul_b = mul_r;
                    end
                end
            end
            StFinX: begin
                if (mul_done) begin
                    mul_start = 1'b1;
                    mul_a     = y_q;
                    mul_b     = acc_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (accept) begin
                        x_q     <= i_x;
                        y_q     <= i_y;
                        z_q     <= i_z;
                        acc_q   <= i_z;
                        // Bit 254 is consumed by acc = Z; the first square serves bit 253.
                        k_q     <= 8'd253;
                        busy_q  <= 1'b1;
                        state_q <= StSqr;
                    end
                end
                StSqr: begin
                    if (mul_done) begin
                        acc_q <= mul_r;
                        if (e_bit) begin
                            state_q <= StMul;
                        end else if (!last_bit) begin
                            k_q <= k_q - 8'd1;
                        end else begin
                            state_q <= StFinX;
                        end
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        acc_q <= mul_r;
                        if (!last_bit) begin
                            k_q     <= k_q - 8'd1;
                            state_q <= StSqr;
                        end else begin
                            state_q <= StFinX;
                        end
                    end
                end
                StFinX: begin
                    if (mul_done) begin
                        ox_q    <= mul_r;
                        state_q <= StFinY;
                    end
                end
                StFinY: begin
                    if (mul_done) begin
                        oy_q    <= mul_r;
                        fin_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    mod_mul #(
        .P(P)
    ) u_mul (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(mul_start),
        .i_a    (mul_a),
        .i_b    (mul_b),
        .o_r    (mul_r),
        .o_done (mul_done)
    );

    assign o_x        = ox_q;
    assign o_y        = oy_q;
    assign o_busy     = busy_q;
    assign o_finished = fin_q;

endmodule

// File: tb/tb_proj_to_affine.sv
module tb_proj_to_affine;

    localparam logic [254:0] P_TB =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [254:0] BX =
        255'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
    localparam logic [254:0] BY =
        255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
    localparam int FIN_CYC = 508 * 256 + 1;
    localparam int N_VEC   = 4;

    logic         clk;
    logic         rst;
    logic         i_start;
    logic [254:0] i_x;
    logic [254:0] i_y;
    logic [254:0] i_z;
    logic [254:0] o_x;
    logic [254:0] o_y;
    logic         o_busy;
    logic         o_finished;

    logic         mm_start;
    logic [254:0] mm_a;
    logic [254:0] mm_b;
    logic [254:0] mm_r;
    logic         mm_done;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [254:0] x;
        logic [254:0] y;
        logic [254:0] z;
        logic [254:0] ex;
        logic [254:0] ey;
        string        name;
    } vec_t;

    vec_t vecs[N_VEC];

    proj_to_affine dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (i_start),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_z       (i_z),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_busy    (o_busy),
        .o_finished(o_finished)
    );

    mod_mul mm (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(mm_start),
        .i_a    (mm_a),
        .i_b    (mm_b),
        .o_r    (mm_r),
        .o_done (mm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: plain wide multiply and modulo.
    function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] prod;
        logic [509:0] rem;
        prod = {255'd0, a} * {255'd0, b};
        rem  = prod % {255'd0, P_TB};
        return rem[254:0];
    endfunction

    // Fermat inverse: z^(p-2) mod p.
    function automatic logic [254:0] inv_model(input logic [254:0] z);
        logic [254:0] ex;
        logic [254:0] r;
        ex = P_TB - 255'd2;
        r  = 255'd1;
        for (int i = 254; i >= 0; i--) begin
            r = mulmod(r, r);
            if (ex[i]) r = mulmod(r, z);
        end
        return r;
    endfunction

    function automatic logic [254:0] rand_fe();
        logic [254:0] v;
        for (int i = 0; i < 8; i++) v = {v[222:0], 32'($urandom)};
        v[254] = 1'b0;
        v = v | {1'b1, 254'd0} & {255{$urandom_range(0, 1) == 1}};
        if (v >= P_TB) v = v - P_TB;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [254:0] act,
                             input logic [254:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mm_op(input logic [254:0] a, input logic [254:0] b,
                         input logic [254:0] exp, input string name);
        int           lat;
        logic [254:0] got;
        lat = -1;
        got = '0;
        @(negedge clk);
        mm_a     = a;
        mm_b     = b;
        mm_start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            mm_start = 1'b0;
            if (mm_done && lat < 0) begin
                lat = c;
                got = mm_r;
            end
        end
        check_int({name, " latency"}, lat, 256);
        check_val({name, " result"}, got, exp);
    endtask

    // Full conversion; start sampled in cycle 0, outputs sampled on negedges.
    // ign_at > 0 pulses a junk i_start in that cycle while busy.
    task automatic run_conv(input logic [254:0] x, input logic [254:0] y,
                            input logic [254:0] z, input logic [254:0] ex,
                            input logic [254:0] ey, input string name, input int ign_at);
        int           fin_cycle;
        int           fin_count;
        int           busy_bad;
        logic [254:0] gx;
        logic [254:0] gy;
        fin_cycle = -1;
        fin_count = 0;
        busy_bad  = -1;
        gx        = '0;
        gy        = '0;
        @(negedge clk);
        i_x     = x;
        i_y     = y;
        i_z     = z;
        i_start = 1'b1;
        for (int c = 1; c <= FIN_CYC + 20; c++) begin
            @(negedge clk);
            i_start = (c == ign_at);
            if (c == ign_at) begin
                i_x = 255'd9;
                i_y = 255'd9;
                i_z = 255'd0;
            end
            if (o_finished) begin
                fin_count++;
                if (fin_cycle < 0) begin
                    fin_cycle = c;
                    gx        = o_x;
                    gy        = o_y;
                end
            end
            if ((o_busy !== (c <= FIN_CYC)) && busy_bad < 0) busy_bad = c;
        end
        check_int({name, " finish cycle"}, fin_cycle, FIN_CYC);
        check_int({name, " finish count"}, fin_count, 1);
        check_int({name, " busy first bad cycle"}, busy_bad, -1);
        check_val({name, " o_x"}, gx, ex);
        check_val({name, " o_y"}, gy, ey);
        check_val({name, " o_x held"}, o_x, ex);
    endtask

    initial begin
        int           late_fin;
        logic [254:0] ra;
        logic [254:0] rb;
        logic [254:0] zi;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_x          = '0;
        i_y          = '0;
        i_z          = '0;
        mm_start     = 1'b0;
        mm_a         = '0;
        mm_b         = '0;

        vecs[0] = '{x: BX, y: BY, z: 255'd1, ex: BX, ey: BY, name: "base_point"};
        vecs[1] = '{x: 255'd9, y: 255'd9, z: 255'd0, ex: 255'd0, ey: 255'd0, name: "z_zero"};
        for (int i = 2; i < N_VEC; i++) begin
            vecs[i].x    = rand_fe();
            vecs[i].y    = rand_fe();
            vecs[i].z    = rand_fe();
            zi           = inv_model(vecs[i].z);
            vecs[i].ex   = mulmod(vecs[i].x, zi);
            vecs[i].ey   = mulmod(vecs[i].y, zi);
            vecs[i].name = $sformatf("random%0d", i);
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset o_x", o_x, '0);
        check_val("reset o_y", o_y, '0);
        check_int("reset o_busy", int'(o_busy), 0);
        check_int("reset o_finished", int'(o_finished), 0);

        mm_op(P_TB - 255'd1, P_TB - 255'd1, 255'd1, "mm (p-1)^2");
        mm_op(255'd3, 255'd5, 255'd15, "mm 3*5");
        for (int i = 0; i < 6; i++) begin
            ra = rand_fe();
            rb = rand_fe();
            mm_op(ra, rb, mulmod(ra, rb), $sformatf("mm random%0d", i));
        end

        // Small point with a junk start while busy.
        run_conv(255'd2, 255'd4, 255'd2, 255'd1, 255'd2, "small", 1000);

        // Reset in the middle of a conversion.
        @(negedge clk);
        i_x     = 255'd5;
        i_y     = 255'd7;
        i_z     = P_TB - 255'd1;
        i_start = 1'b1;
        for (int c = 1; c <= 50000; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (c == 50000) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst o_x", o_x, '0);
        check_val("midrst o_y", o_y, '0);
        check_int("midrst o_busy", int'(o_busy), 0);
        check_int("midrst o_finished", int'(o_finished), 0);
        late_fin = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_finished || o_busy) late_fin++;
        end
        check_int("midrst stays idle", late_fin, 0);

        run_conv(255'd5, 255'd7, P_TB - 255'd1, P_TB - 255'd5, P_TB - 255'd7,
                 "after_reset z=p-1", -1);

        for (int i = 0; i < N_VEC; i++) begin
            run_conv(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].ex, vecs[i].ey,
                     vecs[i].name, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
